can_rx_frame_writer: RTL and testbench
======================================

# can_rx_frame_writer

Receive-side DMA stage between the CAN protocol core and the 16-bit on-chip frame memory (2048 × 16, single-port, Avalon-style write interface). It takes each completed received frame from the CAN core and writes it as a fixed 8-word record into a ring of slots in that memory. It publishes the write slot index, fill level and an overflow count for the Nios-side driver, which consumes records and returns its read slot index.

## Interface
Parameters:
- ADDR_W, 11, memory word-address width.
- Derived: slot index width SLOT_W = ADDR_W-3; slot count 2^SLOT_W, which is 256 at the default.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- frm_valid  in  1  CAN core holds a complete received frame.
- frm_ready  out  1  frame accepted on a cycle where frm_valid & frm_ready.
- frm_ide  in  1  extended-ID flag.
- frm_rtr  in  1  remote-frame flag.
- frm_id  in  29  identifier; standard IDs use bits 10:0 with the upper bits zero.
- frm_dlc  in  4  data length code.
- frm_data  in  64  payload; byte n is bits 8n+7:8n.
- rd_slot  in  SLOT_W  next slot the CPU will read.
- clear_ovf  in  1  one-cycle pulse that clears overflow_cnt.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  2  constant 2'b11.
- mem_chipselect  out  1  equals mem_write.
- mem_write  out  1  write strobe.
- mem_writedata  out  16  write data.
- mem_clken  out  1  constant 1.
- wr_slot  out  SLOT_W  next slot to be written.
- fill_level  out  SLOT_W  (wr_slot - rd_slot) mod 2^SLOT_W.
- overflow_cnt  out  8  count of dropped frames; saturates at 255.
- rx_irq  out  1  one-cycle pulse per committed frame.

## Operation
- FSM states: IDLE, WRITE, COMMIT. frm_ready is 1 only in IDLE.
- Acceptance in IDLE when frm_valid is high:
  - Full condition: (wr_slot+1) mod 2^SLOT_W == rd_slot.
  - If full: the frame is consumed and dropped; overflow_cnt increments, saturating at 255; the FSM stays in IDLE.
  - If not full: all frame fields are latched, the FSM enters WRITE and word counter wc is cleared to 0.
- Slot capacity: one slot is always left empty, so at most 2^SLOT_W-1 records are pending.
- WRITE: one word per cycle, wc counts 0 to 7.
  - mem_write=1, mem_address={wr_slot, wc[2:0]}.
  - After wc=7 the FSM goes to COMMIT.
- Record layout:
  - w0 = {ide, rtr, 2'b00, dlc, seq[7:0]}.
  - w1 = {3'b000, id[28:16]}.
  - w2 = id[15:0].
  - w3 = {d1,d0}, w4 = {d3,d2}, w5 = {d5,d4}, w6 = {d7,d6}.
  - w7 = timestamp (see Configuration).
  - All 8 data bytes are written regardless of dlc; the payload is not masked.
- COMMIT (one cycle):
  - wr_slot increments mod 2^SLOT_W and wraps from 255 to 0 at the default.
  - seq increments mod 256.
  - rx_irq=1.
  - The FSM returns to IDLE.
- clear_ovf: sets overflow_cnt to 0. If clear_ovf and a drop occur in the same cycle, overflow_cnt becomes 1.
- rd_slot is used only as sampled; any value is legal. rd_slot == wr_slot means empty.

## Timing
- Reset values: frm_ready=0 during reset and 1 on the first cycle after; all mem_* strobes 0; mem_address 0; mem_writedata 0; wr_slot 0; seq 0; overflow_cnt 0; rx_irq 0; FSM in IDLE.
- Frame timeline, with the accept edge at cycle 0:
  - mem_write is high in cycles 1–8.
  - COMMIT is cycle 9: rx_irq high, and the new wr_slot is visible from cycle 10.
  - frm_ready is high again in cycle 10.
  - Throughput is one frame per 10 cycles.
- fill_level is combinational from the registered wr_slot and the input rd_slot.
- Memory writes complete in one cycle; there is no waitrequest.
- Reset mid-WRITE: the partial record is abandoned. mem_write is 0 from the reset edge, wr_slot returns to 0 and no rx_irq is produced.

## Configuration
- CAN_RX_TIMESTAMP_EN defined:
  - A 16-bit free-running counter increments every clk and resets to 0.
  - Its value is latched at frame acceptance and written as w7.
- CAN_RX_TIMESTAMP_EN undefined:
  - There is no counter.
  - w7 = 16'h0000; the write is still performed, so timing is unchanged.

## Test plan
- Single frame: ext ID 0x1ABCDEF5, dlc 8, data 0x0807060504030201, rd_slot 0 -> addresses 0..7 written with 0x8800, 0x1ABC, 0xDEF5, 0x0201, 0x0403, 0x0605, 0x0807, then timestamp; rx_irq at cycle 9; wr_slot=1; fill_level=1.
- Fill/overflow: rd_slot held at 0, 256 frames offered -> 255 written, wr_slot=255, 256th dropped with frm_ready high, overflow_cnt=1, no memory write.
- Wrap: rd_slot=10, wr_slot=255 -> frame written at 0x7F8..0x7FF; wr_slot=0; seq continues.
- Clear race: overflow_cnt=5; clear_ovf in the same cycle as a drop -> overflow_cnt=1. 300 drops -> overflow_cnt=255.
- Reset at wc=3 -> mem_write=0 on the next cycle; wr_slot=0; no rx_irq; next frame written at address 0 with seq 0.
- Timestamp: macro defined, frames accepted 100 cycles apart -> w7 values differ by 100. Macro undefined -> w7=0x0000.

Source files
------------

// File: rtl/can_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : can_rx_frame_writer
// Function : Writes each received CAN frame as an 8-word record into a slot
//            ring in 16-bit frame memory. Optional macro: CAN_RX_TIMESTAMP_EN.
// Revision : 1.0
// ============================================================================
module can_rx_frame_writer #(
    parameter  int ADDR_W = 11,
    localparam int SLOT_W = ADDR_W - 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frm_valid,
    output logic              frm_ready,
    input  logic              frm_ide,
    input  logic              frm_rtr,
    input  logic [28:0]       frm_id,
    input  logic [3:0]        frm_dlc,
    input  logic [63:0]       frm_data,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic              clear_ovf,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic              mem_clken,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [SLOT_W-1:0] fill_level,
    output logic [7:0]        overflow_cnt,
    output logic              rx_irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          wc_q, wc_d;
    logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
    logic [7:0]          seq_q, seq_d;
    logic [7:0]          ovf_q, ovf_d;
    logic                ide_q, ide_d;
    logic                rtr_q, rtr_d;
    logic [28:0]         id_q, id_d;
    logic [3:0]          dlc_q, dlc_d;
    logic [63:0]         data_q, data_d;

    logic [SLOT_W-1:0]   w_slot_next;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;
    logic [15:0]         w_ts_word;

`ifdef CAN_RX_TIMESTAMP_EN
    logic [15:0]         ts_cnt_q, ts_cnt_d;
    logic [15:0]         ts_lat_q, ts_lat_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + 16'd1;
        ts_lat_d = w_accept ? ts_cnt_q : ts_lat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_lat_q <= ts_lat_d;
        end
    end

    assign w_ts_word = ts_lat_q;
`else
    assign w_ts_word = 16'h0000;
`endif

    // One slot is kept empty so that rd_slot == wr_slot always means empty.
    assign w_slot_next = wr_slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
    assign w_full      = (w_slot_next == rd_slot);
    assign w_accept    = frm_valid && frm_ready && !w_full;
    assign w_drop      = frm_valid && frm_ready && w_full;

    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;
    assign mem_chipselect = mem_write;
    assign wr_slot        = wr_slot_q;
    assign fill_level     = wr_slot_q - rd_slot;
    assign overflow_cnt   = ovf_q;

    always_comb begin
        state_d       = state_q;
        wc_d          = wc_q;
        wr_slot_d     = wr_slot_q;
        seq_d         = seq_q;
        ide_d         = ide_q;
        rtr_d         = rtr_q;
        id_d          = id_q;
        dlc_d         = dlc_q;
        data_d        = data_q;
        frm_ready     = (state_q == S_IDLE) && !reset;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = 16'h0000;
        rx_irq        = 1'b0;

        // A clear coinciding with a drop still counts that drop.
        if (clear_ovf) begin
            ovf_d = {7'd0, w_drop};
        end else if (w_drop && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    ide_d   = frm_ide;
                    rtr_d   = frm_rtr;
                    id_d    = frm_id;
                    dlc_d   = frm_dlc;
                    data_d  = frm_data;
                    wc_d    = 3'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_write   = 1'b1;
                mem_address = {wr_slot_q, wc_q};
                case (wc_q)
                    3'd0:    mem_writedata = {ide_q, rtr_q, 2'b00, dlc_q, seq_q};
                    3'd1:    mem_writedata = {3'b000, id_q[28:16]};
                    3'd2:    mem_writedata = id_q[15:0];
                    3'd3:    mem_writedata = data_q[15:0];
                    3'd4:    mem_writedata = data_q[31:16];
                    3'd5:    mem_writedata = data_q[47:32];
                    3'd6:    mem_writedata = data_q[63:48];
                    default: mem_writedata = w_ts_word;
                endcase
                wc_d = wc_q + 3'd1;
                if (wc_q == 3'd7) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                rx_irq    = 1'b1;
                wr_slot_d = w_slot_next;
                seq_d     = seq_q + 8'd1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wc_q      <= '0;
            wr_slot_q <= '0;
            seq_q     <= '0;
            ovf_q     <= '0;
            ide_q     <= 1'b0;
            rtr_q     <= 1'b0;
            id_q      <= '0;
            dlc_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            wr_slot_q <= wr_slot_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            ide_q     <= ide_d;
            rtr_q     <= rtr_d;
            id_q      <= id_d;
            dlc_q     <= dlc_d;
            data_q    <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_can_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_rx_frame_writer
// Function : Directed self-checking bench for can_rx_frame_writer.
// Revision : 1.0
// ============================================================================
module tb_can_rx_frame_writer;

    localparam int ADDR_W = 11;
    localparam int SLOT_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frm_valid = 1'b0;
    logic              frm_ready;
    logic              frm_ide = 1'b0;
    logic              frm_rtr = 1'b0;
    logic [28:0]       frm_id = '0;
    logic [3:0]        frm_dlc = '0;
    logic [63:0]       frm_data = '0;
    logic [SLOT_W-1:0] rd_slot = '0;
    logic              clear_ovf = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [15:0]       mem_writedata;
    logic              mem_clken;
    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] fill_level;
    logic [7:0]        overflow_cnt;
    logic              rx_irq;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] mem_model [0:2047];

    can_rx_frame_writer #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_ide        (frm_ide),
        .frm_rtr        (frm_rtr),
        .frm_id         (frm_id),
        .frm_dlc        (frm_dlc),
        .frm_data       (frm_data),
        .rd_slot        (rd_slot),
        .clear_ovf      (clear_ovf),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .wr_slot        (wr_slot),
        .fill_level     (fill_level),
        .overflow_cnt   (overflow_cnt),
        .rx_irq         (rx_irq)
    );

    always #5 clk = ~clk;

    // Record what the DUT writes into a memory image, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            mem_model[mem_address] = mem_writedata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one cycle after the accept edge (first WRITE cycle).
    task automatic offer(input logic ide, input logic rtr, input logic [28:0] id,
                         input logic [3:0] dlc, input logic [63:0] data);
        int n;
        n = 0;
        frm_ide   = ide;
        frm_rtr   = rtr;
        frm_id    = id;
        frm_dlc   = dlc;
        frm_data  = data;
        frm_valid = 1'b1;
        while (frm_ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) begin
            total_cnt++;
            $display("FAIL offer_timeout: frm_ready got %b, expected 1", frm_ready);
        end else begin
            step(1);
        end
        frm_valid = 1'b0;
    endtask

    task automatic send(input logic ide, input logic rtr, input logic [28:0] id,
                        input logic [3:0] dlc, input logic [63:0] data);
        offer(ide, rtr, id, dlc, data);
        step(9);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(3);
        total_cnt++;
        if ({frm_ready, mem_write, mem_chipselect, rx_irq} !== 4'b0000)
            $display("FAIL reset_strobes: got %b, expected 0000", {frm_ready, mem_write, mem_chipselect, rx_irq});
        else pass_cnt++;
        total_cnt++;
        if ({mem_address, mem_writedata} !== 27'd0)
            $display("FAIL reset_addr_data: got %h/%h, expected 0/0", mem_address, mem_writedata);
        else pass_cnt++;
        total_cnt++;
        if ({wr_slot, fill_level, overflow_cnt} !== 24'd0)
            $display("FAIL reset_counters: got %h/%h/%h, expected 0/0/0", wr_slot, fill_level, overflow_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({mem_byteenable, mem_clken} !== 3'b111)
            $display("FAIL reset_constants: got %b, expected 111", {mem_byteenable, mem_clken});
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (frm_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b, expected 1", frm_ready);
        else pass_cnt++;
    endtask

    task automatic test_single_frame;
        logic [15:0] exp_w [8];
        int          w0;
        exp_w = '{16'h8800, 16'h1ABC, 16'hDEF5, 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0000};
        rd_slot = 8'd0;
        w0 = wr_cnt;
        offer(1'b1, 1'b0, 29'h1ABCDEF5, 4'd8, 64'h0807060504030201);
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if ({mem_write, mem_address} !== {1'b1, 11'(k)})
                $display("FAIL single_addr%0d: got %b/%h, expected 1/%h", k, mem_write, mem_address, k);
            else pass_cnt++;
            if (k < 7) begin
                total_cnt++;
                if (mem_writedata !== exp_w[k])
                    $display("FAIL single_w%0d: got %h, expected %h", k, mem_writedata, exp_w[k]);
                else pass_cnt++;
            end
            step(1);
        end
`ifndef CAN_RX_TIMESTAMP_EN
        total_cnt++;
        if (mem_model[7] !== 16'h0000)
            $display("FAIL single_w7_zero: got %h, expected 0000", mem_model[7]);
        else pass_cnt++;
`endif
        total_cnt++;
        if ({rx_irq, mem_write, frm_ready, wr_slot} !== {3'b100, 8'd0})
            $display("FAIL single_commit: got irq/wr/rdy/slot %b%b%b/%h, expected 100/00", rx_irq, mem_write, frm_ready, wr_slot);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({rx_irq, frm_ready, wr_slot, fill_level} !== {2'b01, 8'd1, 8'd1})
            $display("FAIL single_done: got irq/rdy %b%b slot %h fill %h, expected 01 01 01", rx_irq, frm_ready, wr_slot, fill_level);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - w0 !== 8)
            $display("FAIL single_write_count: got %0d, expected 8", wr_cnt - w0);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow;
        int w0;
        rd_slot = 8'd0;
        for (int i = 0; i < 254; i++) begin
            send(1'b0, 1'b0, 29'(i), 4'd0, 64'd0);
        end
        total_cnt++;
        if ({wr_slot, fill_level} !== {8'd255, 8'd255})
            $display("FAIL fill_level_full: got slot %h fill %h, expected ff ff", wr_slot, fill_level);
        else pass_cnt++;
        w0 = wr_cnt;
        frm_valid = 1'b1;
        total_cnt++;
        if (frm_ready !== 1'b1)
            $display("FAIL full_ready: got %b, expected 1", frm_ready);
        else pass_cnt++;
        step(1);
        frm_valid = 1'b0;
        total_cnt++;
        if ({overflow_cnt, frm_ready, mem_write} !== {8'd1, 2'b10})
            $display("FAIL drop_first: got ovf %h rdy/wr %b%b, expected 01 10", overflow_cnt, frm_ready, mem_write);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if ({wr_cnt - w0, 32'(wr_slot)} !== {32'd0, 32'd255})
            $display("FAIL drop_no_write: got writes %0d slot %h, expected 0 ff", wr_cnt - w0, wr_slot);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        rd_slot = 8'd10;
        #1;
        total_cnt++;
        if (fill_level !== 8'd245)
            $display("FAIL wrap_fill_before: got %h, expected f5", fill_level);
        else pass_cnt++;
        send(1'b1, 1'b1, 29'h7FF, 4'd2, 64'h1122334455667788);
        total_cnt++;
        if ({mem_model[11'h7F8], mem_model[11'h7F9], mem_model[11'h7FA], mem_model[11'h7FB], mem_model[11'h7FE]}
                !== {16'hC2FF, 16'h0000, 16'h07FF, 16'h7788, 16'h1122})
            $display("FAIL wrap_record: got %h %h %h %h %h, expected c2ff 0000 07ff 7788 1122",
                     mem_model[11'h7F8], mem_model[11'h7F9], mem_model[11'h7FA], mem_model[11'h7FB], mem_model[11'h7FE]);
        else pass_cnt++;
        total_cnt++;
        if ({wr_slot, fill_level} !== {8'd0, 8'd246})
            $display("FAIL wrap_slot: got slot %h fill %h, expected 00 f6", wr_slot, fill_level);
        else pass_cnt++;
        send(1'b0, 1'b0, 29'h123, 4'd1, 64'd0);
        total_cnt++;
        if ({mem_model[0], wr_slot} !== {16'h0100, 8'd1})
            $display("FAIL wrap_seq_continue: got w0 %h slot %h, expected 0100 01", mem_model[0], wr_slot);
        else pass_cnt++;
    endtask

    task automatic test_clear_race;
        int w0;
        w0 = wr_cnt;
        rd_slot = 8'd2;
        frm_valid = 1'b1;
        step(4);
        total_cnt++;
        if (overflow_cnt !== 8'd5)
            $display("FAIL ovf_count5: got %0d, expected 5", overflow_cnt);
        else pass_cnt++;
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        total_cnt++;
        if (overflow_cnt !== 8'd1)
            $display("FAIL clear_race: got %0d, expected 1", overflow_cnt);
        else pass_cnt++;
        step(300);
        frm_valid = 1'b0;
        total_cnt++;
        if (overflow_cnt !== 8'd255)
            $display("FAIL ovf_saturate: got %0d, expected 255", overflow_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({wr_cnt - w0, 32'(wr_slot)} !== {32'd0, 32'd1})
            $display("FAIL drops_no_write: got writes %0d slot %h, expected 0 01", wr_cnt - w0, wr_slot);
        else pass_cnt++;
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        total_cnt++;
        if (overflow_cnt !== 8'd0)
            $display("FAIL clear_only: got %0d, expected 0", overflow_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write;
        int irq_seen;
        irq_seen = 0;
        rd_slot = 8'd0;
        offer(1'b1, 1'b0, 29'h1FFFFFFF, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF);
        step(3);
        total_cnt++;
        if ({mem_write, mem_address} !== {1'b1, 11'h00B})
            $display("FAIL midwrite_wc3: got %b/%h, expected 1/00b", mem_write, mem_address);
        else pass_cnt++;
        reset = 1'b1;
        step(1);
        total_cnt++;
        if ({mem_write, rx_irq, frm_ready, wr_slot} !== {3'b000, 8'd0})
            $display("FAIL midwrite_reset: got wr/irq/rdy %b%b%b slot %h, expected 000 00", mem_write, rx_irq, frm_ready, wr_slot);
        else pass_cnt++;
        reset = 1'b0;
        repeat (12) begin
            step(1);
            if (rx_irq === 1'b1) irq_seen++;
        end
        total_cnt++;
        if (irq_seen !== 0)
            $display("FAIL midwrite_no_irq: got %0d pulses, expected 0", irq_seen);
        else pass_cnt++;
        mem_model[0] = 16'hDEAD;
        send(1'b0, 1'b1, 29'h2A, 4'd3, 64'd0);
        total_cnt++;
        if ({mem_model[0], mem_model[2], wr_slot} !== {16'h4300, 16'h002A, 8'd1})
            $display("FAIL after_reset_frame: got %h %h slot %h, expected 4300 002a 01", mem_model[0], mem_model[2], wr_slot);
        else pass_cnt++;
    endtask

    task automatic test_timestamp;
        logic [15:0] ta;
        logic [15:0] tb;
        rd_slot = 8'd1;
        offer(1'b0, 1'b0, 29'h1, 4'd0, 64'd0);
        step(99);
        offer(1'b0, 1'b0, 29'h2, 4'd0, 64'd0);
        step(9);
        ta = mem_model[15];
        tb = mem_model[23];
`ifdef CAN_RX_TIMESTAMP_EN
        total_cnt++;
        if (16'(tb - ta) !== 16'd100)
            $display("FAIL ts_delta: got %0d, expected 100", 16'(tb - ta));
        else pass_cnt++;
`else
        total_cnt++;
        if ({ta, tb} !== 32'd0)
            $display("FAIL ts_zero: got %h %h, expected 0000 0000", ta, tb);
        else pass_cnt++;
`endif
        total_cnt++;
        if (wr_slot !== 8'd3)
            $display("FAIL ts_slot: got %h, expected 03", wr_slot);
        else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overflow();
        test_wrap();
        test_clear_race();
        test_reset_mid_write();
        test_timestamp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
